// File: rtl/calc_key_sequencer_if.sv
// Keypad/calculator handshake bundle for calc_key_sequencer.
// master = keypad + calculator side, slave = sequencer.
interface calc_key_sequencer_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic [3:0] calc_a;
  logic [3:0] calc_b;
  logic [2:0] calc_func;
  logic       calc_get_res;
  logic [7:0] calc_res;
  logic [7:0] result;
  logic       result_valid;
  logic       error;
  logic       busy;

  modport master (
    output key_valid,
    output key_code,
    output calc_res,
    input  key_ready,
    input  calc_a,
    input  calc_b,
    input  calc_func,
    input  calc_get_res,
    input  result,
    input  result_valid,
    input  error,
    input  busy
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  calc_res,
    output key_ready,
    output calc_a,
    output calc_b,
    output calc_func,
    output calc_get_res,
    output result,
    output result_valid,
    output error,
    output busy
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Key sequencer feeding a 4-bit calculator; optional divide-by-zero
// guard enabled by defining CALC_DIV_ZERO_GUARD_EN.
module calc_key_sequencer #(
  parameter int unsigned PULSE_LEN = 2
) (
  input logic                  clk,
  input logic                  rst,
  calc_key_sequencer_if.slave  bus
);

  localparam logic [3:0] PL = 4'(PULSE_LEN);

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_EQ,
    S_FIRE,
    S_GAP,
    S_CAP
  } state_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_DIGIT,
    K_OP,
    K_EQ,
    K_CLR
  } key_t;

  state_t     state;
  key_t       kind;
  logic [3:0] cnt;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] func_q;
  logic       get_res_q;
  logic [7:0] result_q;
  logic       rv_q;
  logic       err_q;
  logic       ready_q;
  logic       busy_q;
  logic [3:0] dig;

  assign dig = bus.key_code[3:0];

  // Keys are only classified while ready; everything else is dropped.
  always_comb begin
    kind = K_NONE;
    if (bus.key_valid && ready_q) begin
      unique case (1'b1)
        !bus.key_code[4]:
          kind = K_DIGIT;
        (bus.key_code[4:3] == 2'b10) &&
        (bus.key_code[2:0] <= 3'd5):
          kind = K_OP;
        bus.key_code == 5'd22:
          kind = K_EQ;
        bus.key_code == 5'd23:
          kind = K_CLR;
        default:
          kind = K_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_A;
      cnt       <= 4'd0;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      func_q    <= 3'd0;
      get_res_q <= 1'b0;
      result_q  <= 8'd0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else if (kind == K_CLR) begin
      state    <= S_A;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      func_q   <= 3'd0;
      result_q <= 8'd0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        S_A: begin
          ready_q <= 1'b1;
          if (kind == K_DIGIT) begin
            a_q   <= dig;
            rv_q  <= 1'b0;
            err_q <= 1'b0;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (kind == K_OP) begin
            func_q <= bus.key_code[2:0];
            state  <= S_B;
          end else if (kind == K_DIGIT) begin
            a_q <= dig;
          end
        end
        S_B: begin
          if (kind == K_DIGIT) begin
            b_q   <= dig;
            state <= S_EQ;
          end
        end
        S_EQ: begin
          if (kind == K_DIGIT) begin
            b_q <= dig;
          end else if (kind == K_EQ) begin
`ifdef CALC_DIV_ZERO_GUARD_EN
            if (func_q == 3'b011 && b_q == 4'd0) begin
              err_q    <= 1'b1;
              result_q <= 8'hFF;
              rv_q     <= 1'b0;
              state    <= S_A;
            end else begin
              get_res_q <= 1'b1;
              cnt       <= 4'd1;
              busy_q    <= 1'b1;
              ready_q   <= 1'b0;
              state     <= S_FIRE;
            end
`else
            get_res_q <= 1'b1;
            cnt       <= 4'd1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state     <= S_FIRE;
`endif
          end
        end
        S_FIRE: begin
          // cnt holds the number of high cycles already started.
          if (cnt == PL) begin
            get_res_q <= 1'b0;
            cnt       <= 4'd0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_GAP: begin
          state <= S_CAP;
        end
        S_CAP: begin
          result_q <= bus.calc_res;
          rv_q     <= 1'b1;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
          state    <= S_A;
        end
        default: begin
          state <= S_A;
        end
      endcase
    end
  end

  assign bus.key_ready    = ready_q;
  assign bus.calc_a       = a_q;
  assign bus.calc_b       = b_q;
  assign bus.calc_func    = func_q;
  assign bus.calc_get_res = get_res_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.error        = err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer with a behavioural
// calculator that evaluates on the rising edge of calc_get_res.
module tb_calc_key_sequencer;

  localparam int P = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   edge_cnt;
  int   eq_edge;
  int   run;
  int   pulses;
  int   last_len;
  logic rv_prev;
  logic [7:0] sbq[$];

  calc_key_sequencer_if bus ();

  calc_key_sequencer #(.PULSE_LEN(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  function automatic logic [7:0] calc(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] f
  );
    logic [7:0] wa;
    logic [7:0] wb;
    wa = {4'd0, a};
    wb = {4'd0, b};
    case (f)
      3'd0: calc = wa + wb;
      3'd1: calc = wa - wb;
      3'd2: calc = wa * wb;
      3'd3: calc = (b == 4'd0) ? 8'hFF : wa / wb;
      3'd4: calc = wa & wb;
      3'd5: calc = wa | wb;
      default: calc = 8'd0;
    endcase
  endfunction

  initial bus.calc_res = 8'd0;
  always @(posedge bus.calc_get_res)
    bus.calc_res <= calc(bus.calc_a, bus.calc_b, bus.calc_func);

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Pulse-width monitor and result scoreboard.
  always @(negedge clk) begin
    if (bus.calc_get_res) begin
      run++;
    end else if (run > 0) begin
      last_len = run;
      pulses++;
      run = 0;
    end
    if (bus.result_valid && !rv_prev) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        check("sb_result", bus.result, sbq.pop_front());
        check("latency", edge_cnt - eq_edge, P + 2);
      end
    end
    rv_prev = bus.result_valid;
  end

  task automatic press(input logic [4:0] code);
    int i;
    @(negedge clk);
    for (i = 0; i < 40 && !bus.key_ready; i++) @(negedge clk);
    if (!bus.key_ready) check("ready_wait", 0, 1);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    if (code == 5'd22) eq_edge = edge_cnt;
  endtask

  task automatic wait_done();
    int i;
    @(negedge clk);
    for (i = 0; i < 40 && !bus.result_valid; i++) @(negedge clk);
    check("done", bus.result_valid, 1);
  endtask

  task automatic run_op(
    input logic [3:0] a,
    input logic [2:0] f,
    input logic [3:0] b
  );
    sbq.push_back(calc(a, b, f));
    press({1'b0, a});
    press({2'b10, f});
    press({1'b0, b});
    press(5'd22);
    wait_done();
    check("hold_a", bus.calc_a, a);
    check("hold_b", bus.calc_b, b);
    check("hold_f", bus.calc_func, f);
  endtask

  initial begin
    int p0;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] rf;
    n_chk = 0; n_pass = 0; edge_cnt = 0; eq_edge = 0;
    run = 0; pulses = 0; last_len = 0; rv_prev = 1'b0;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.key_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_getres", bus.calc_get_res, 0);
    check("rst_result", bus.result, 0);
    check("rst_a", bus.calc_a, 0);
    check("rst_err", bus.error, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_rst", bus.key_ready, 1);

    // 3 + 5
    p0 = pulses;
    sbq.push_back(8'h08);
    press(5'd3); press(5'd16); press(5'd5); press(5'd22);
    check("a_3", bus.calc_a, 3);
    check("f_add", bus.calc_func, 0);
    check("b_5", bus.calc_b, 5);
    check("busy_fire", bus.busy, 1);
    wait_done();
    check("pulse_cnt", pulses - p0, 1);
    check("pulse_len", last_len, P);

    // F * F, then new digit drops result_valid
    sbq.push_back(8'hE1);
    press(5'd15); press(5'd18); press(5'd15); press(5'd22);
    wait_done();
    press(5'd1);
    check("rv_drop", bus.result_valid, 0);
    check("a_new", bus.calc_a, 1);
    press(5'd23);

    // overwrite operands: 2 7 - 4 6 =
    sbq.push_back(8'h01);
    press(5'd2); press(5'd7); press(5'd17);
    press(5'd4); press(5'd6); press(5'd22);
    check("ow_a", bus.calc_a, 7);
    check("ow_b", bus.calc_b, 6);
    check("ow_f", bus.calc_func, 1);
    wait_done();

    // 9 / 0
    p0 = pulses;
`ifdef CALC_DIV_ZERO_GUARD_EN
    press(5'd9); press(5'd19); press(5'd0); press(5'd22);
    repeat (6) @(negedge clk);
    check("dz_err", bus.error, 1);
    check("dz_result", bus.result, 8'hFF);
    check("dz_rv", bus.result_valid, 0);
    check("dz_pulses", pulses - p0, 0);
    check("dz_busy", bus.busy, 0);
`else
    sbq.push_back(8'hFF);
    press(5'd9); press(5'd19); press(5'd0); press(5'd22);
    wait_done();
    check("dz_err", bus.error, 0);
    check("dz_pulses", pulses - p0, 1);
    check("dz_len", last_len, P);
`endif

    // clear then stray equals
    p0 = pulses;
    press(5'd4); press(5'd16); press(5'd23);
    @(negedge clk);
    check("clr_a", bus.calc_a, 0);
    check("clr_b", bus.calc_b, 0);
    check("clr_f", bus.calc_func, 0);
    check("clr_result", bus.result, 0);
    check("clr_rv", bus.result_valid, 0);
    check("clr_err", bus.error, 0);
    press(5'd22);
    press(5'd25);
    repeat (6) @(negedge clk);
    check("clr_pulses", pulses - p0, 0);
    check("clr_busy", bus.busy, 0);
    check("rsv_a", bus.calc_a, 0);

    // key while busy, then reset in 2nd S_FIRE cycle
    press(5'd5); press(5'd16); press(5'd5); press(5'd22);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'd23;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    check("busy_drop_a", bus.calc_a, 5);
    check("busy_hi", bus.busy, 1);
    check("fire2_getres", bus.calc_get_res, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_fire_getres", bus.calc_get_res, 0);
    check("rst_fire_rv", bus.result_valid, 0);
    check("rst_fire_a", bus.calc_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_fire_nocap", bus.result_valid, 0);

    for (int k = 0; k < 8; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rf = 3'($urandom_range(0, 5));
      if (rf == 3'd3 && rb == 4'd0) rb = 4'd1;
      run_op(ra, rf, rb);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 Parameter PULSE_LEN, default 2: calc_get_res high time in clk cycles; legal range 1-15.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 key_valid  in  1  one-cycle key strobe; sampled only when key_ready=1.
REQ-005 key_code  in  5  key code: 0-15 hex digit; 16-21 operator (func = code-16: add, sub, mul, div, and, or); 22 equals; 23 clear; 24-31 reserved.
REQ-006 key_ready  out  1  high when a key is accepted this cycle.
REQ-007 calc_a, calc_b  out  4 each  operand nibbles to the calculator.
REQ-008 calc_func  out  3  operation select to the calculator.
REQ-009 calc_get_res  out  1  registered strobe; calculator evaluates on its rising edge.
REQ-010 calc_res  in  8  calculator result.
REQ-011 result  out  8  captured result; result_valid  out  1  result holds a completed computation.
REQ-012 error  out  1  rejected computation flag; busy  out  1  high in S_FIRE, S_GAP, S_CAP.

Function
REQ-013 States: S_A, S_OP, S_B, S_EQ, S_FIRE, S_GAP, S_CAP; key_ready=1 only in S_A, S_OP, S_B, S_EQ.
REQ-014 S_A: digit -> calc_a=digit, result_valid=0, error=0, go S_OP; other non-clear keys ignored.
REQ-015 S_OP: operator -> calc_func latched, go S_B; digit -> calc_a overwritten, stay.
REQ-016 S_B: digit -> calc_b latched, go S_EQ; other non-clear keys ignored.
REQ-017 S_EQ: equals -> go S_FIRE; digit -> calc_b overwritten, stay; operator ignored.
REQ-018 Clear (23) in any key_ready state: calc_a, calc_b, calc_func, result, result_valid, error -> 0; go S_A.
REQ-019 Reserved codes 24-31 and keys while key_ready=0 are dropped with no state change.
REQ-020 S_FIRE: calc_get_res=1 for exactly PULSE_LEN cycles (4-bit counter), then S_GAP.
REQ-021 S_GAP: calc_get_res=0 for one cycle, then S_CAP.
REQ-022 S_CAP: result<=calc_res, result_valid<=1, go S_A; calc_a/calc_b/calc_func hold values.
REQ-023 Latency: result_valid rises PULSE_LEN+2 rising edges after the edge accepting equals.
REQ-024 calc_a, calc_b, calc_func stable from S_FIRE entry through S_CAP exit.
REQ-025 result/result_valid held until the next digit accepted in S_A or clear.
REQ-026 calc_get_res driven only from a flop; no glitches.

Reset
REQ-027 rst=1 forces immediately, independent of clk: state S_A, all outputs 0 (key_ready=1 after release), counter 0.
REQ-028 Reset during S_FIRE drops calc_get_res in the same cycle; computation discarded, no capture.

Configuration
REQ-029 Macro CALC_DIV_ZERO_GUARD_EN defined: equals in S_EQ with calc_func=3'b011 and calc_b=0 -> no strobe, error=1, result=8'hFF, result_valid=0, go S_A.
REQ-030 Macro undefined: divide-by-zero issued like any operation; result is whatever calc_res returns; error constant 0.

Verification
REQ-031 Keys 3, 16, 5, 22 (PULSE_LEN=2) -> calc_a=3, calc_func=000, calc_b=5, get_res high 2 cycles, model res=8'h08 -> result=8'h08, result_valid 4 edges after equals.
REQ-032 Keys F, 18, F, 22 -> result=8'hE1; next digit 1 -> result_valid=0, calc_a=1.
REQ-033 Keys 9, 19, 0, 22 with macro -> error=1, result=8'hFF, no get_res edge; without macro -> one PULSE_LEN pulse, error=0.
REQ-034 Keys 2, 7, 17, 4, 6, 22 -> calc_a=7, calc_b=6, calc_func=001, result=8'h01.
REQ-035 rst asserted in 2nd S_FIRE cycle -> get_res=0 before next edge, result_valid=0; keys ignored while busy=1.
REQ-036 Keys 4, 16, 23, then 22 -> after clear all zero in S_A; equals ignored, no strobe.
